// File: rtl/seg_pkg.sv
// Shared types and segment encoding for the multiplexed 7-segment scan controller.
// Segment vectors are active-low, ordered a..g from bit 6 down to bit 0.
package seg_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG_OFF = 7'h7F;

    localparam seg7_t SEG_LUT [16] = '{
        7'b0000001,  // 0
        7'b1001111,  // 1
        7'b0010010,  // 2
        7'b0000110,  // 3
        7'b1001100,  // 4
        7'b0100100,  // 5
        7'b0100000,  // 6
        7'b0001111,  // 7
        7'b0000000,  // 8
        7'b0000100,  // 9
        7'b0001000,  // A
        7'b1100000,  // b
        7'b0110001,  // C
        7'b1000010,  // d
        7'b0110000,  // E
        7'b0111000   // F
    };

endpackage

// File: rtl/seg_scan_if.sv
// Host-side bundle for the scan controller: update strobe/data in, display drive out.
interface seg_scan_if #(
    parameter int NDIG = 8
);
    import seg_pkg::*;

    logic                en;
    logic                load;
    logic [4*NDIG-1:0]   value;
    logic [NDIG-1:0]     dp_in;
    logic                lz_en;
    logic [NDIG-1:0]     an;
    seg7_t               seg;
    logic                dp;
    logic                frame;

    modport master (
        output en, load, value, dp_in, lz_en,
        input  an, seg, dp, frame
    );

    modport slave (
        input  en, load, value, dp_in, lz_en,
        output an, seg, dp, frame
    );

endinterface

// File: rtl/hex7seg_dec.sv
// Hex nibble to active-low 7-segment pattern, pure table lookup.
module hex7seg_dec
    import seg_pkg::*;
(
    input  logic [3:0] hex,
    output seg7_t      seg
);

    assign seg = SEG_LUT[hex];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan of NDIG hex digits over one shared segment bus, with
// frame-synchronous double buffering, leading-zero blanking and per-digit dp.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NDIG = 8,
    parameter int DIV  = 50000
)(
    input  logic      clk,
    input  logic      rst_n,
    seg_scan_if.slave bus
);

    localparam int CW = (DIV  > 1) ? $clog2(DIV)  : 1;
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [NDIG-1:0] AN_ONE = {{(NDIG-1){1'b0}}, 1'b1};

    logic [CW-1:0]      cnt;
    logic [IW-1:0]      idx;
    logic               tick;
    logic               wrap;

    logic [4*NDIG-1:0]  pend_val;
    logic [NDIG-1:0]    pend_dp;
    logic               pend_lz;
    logic               pend_v;

    logic [4*NDIG-1:0]  disp_val;
    logic [NDIG-1:0]    disp_dp;
    logic [NDIG-1:0]    mask;

    logic [3:0]         nib;
    seg7_t              dec_seg;

    logic [NDIG-1:0]    an_p1;
    seg7_t              seg_p1;
    logic               dp_p1;
    logic               frame_p1;

    // Digit k (k >= 1) is blank when it and every more significant nibble is zero.
    function automatic logic [NDIG-1:0] lz_mask(input logic [4*NDIG-1:0] v,
                                                input logic              lz);
        logic [NDIG-1:0] m;
        logic            upper_zero;
        m          = '0;
        upper_zero = 1'b1;
        for (int k = NDIG - 1; k >= 1; k--) begin
            upper_zero = upper_zero && (v[4*k +: 4] == 4'h0);
            m[k]       = lz && upper_zero;
        end
        return m;
    endfunction

    assign tick = bus.en && (cnt == CW'(DIV - 1));
    assign wrap = tick && (idx == IW'(NDIG - 1));

    // Divider and digit index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (bus.en) begin
            if (tick) begin
                cnt <= '0;
                idx <= wrap ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Pending/display buffers; a load coinciding with commit stays pending
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_val <= '0;
            pend_dp  <= '0;
            pend_lz  <= 1'b0;
            pend_v   <= 1'b0;
            disp_val <= '0;
            disp_dp  <= '0;
            mask     <= '0;
        end else begin
            if (wrap && pend_v) begin
                disp_val <= pend_val;
                disp_dp  <= pend_dp;
                mask     <= lz_mask(pend_val, pend_lz);
            end
            if (bus.load) begin
                pend_val <= bus.value;
                pend_dp  <= bus.dp_in;
                pend_lz  <= bus.lz_en;
                pend_v   <= 1'b1;
            end else if (wrap && pend_v) begin
                pend_v   <= 1'b0;
            end
        end
    end

    always_comb begin
        nib = disp_val[{idx, 2'b00} +: 4];
    end

    hex7seg_dec u_dec (
        .hex (nib),
        .seg (dec_seg)
    );

    // Output stage: blank on disable and for the ghost cycle after each tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_p1    <= '1;
            seg_p1   <= SEG_OFF;
            dp_p1    <= 1'b1;
            frame_p1 <= 1'b0;
        end else begin
            frame_p1 <= wrap;
            if (!bus.en || tick) begin
                an_p1  <= '1;
                seg_p1 <= SEG_OFF;
                dp_p1  <= 1'b1;
            end else begin
                an_p1  <= ~(AN_ONE << idx);
                seg_p1 <= mask[idx] ? SEG_OFF : dec_seg;
                dp_p1  <= mask[idx] | ~disp_dp[idx];
            end
        end
    end

    assign bus.an    = an_p1;
    assign bus.seg   = seg_p1;
    assign bus.dp    = dp_p1;
    assign bus.frame = frame_p1;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized and directed bench for seg_scan_ctrl against a count-based display model.
module tb_seg_scan_ctrl;
    import seg_pkg::*;

    localparam int NDIG  = 4;
    localparam int DIV   = 4;
    localparam int FRAME = NDIG * DIV;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    seg_scan_if #(.NDIG(NDIG)) bus ();

    seg_scan_ctrl #(.NDIG(NDIG), .DIV(DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;

    // Model: enabled-edge count since reset plus committed/pending frame contents
    int          ecnt;
    logic [15:0] m_disp, m_pend;
    logic [3:0]  m_ddp, m_pdp;
    logic        m_dlz, m_plz, m_pv;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp, e_frame;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] ref_seg(input logic [3:0] h);
        case (h)
            4'h0: ref_seg = 7'b0000001;  4'h1: ref_seg = 7'b1001111;
            4'h2: ref_seg = 7'b0010010;  4'h3: ref_seg = 7'b0000110;
            4'h4: ref_seg = 7'b1001100;  4'h5: ref_seg = 7'b0100100;
            4'h6: ref_seg = 7'b0100000;  4'h7: ref_seg = 7'b0001111;
            4'h8: ref_seg = 7'b0000000;  4'h9: ref_seg = 7'b0000100;
            4'hA: ref_seg = 7'b0001000;  4'hB: ref_seg = 7'b1100000;
            4'hC: ref_seg = 7'b0110001;  4'hD: ref_seg = 7'b1000010;
            4'hE: ref_seg = 7'b0110000;  default: ref_seg = 7'b0111000;
        endcase
    endfunction

    task automatic model_reset();
        ecnt   = 0;
        m_disp = '0; m_ddp = '0; m_dlz = 1'b0;
        m_pend = '0; m_pdp = '0; m_plz = 1'b0; m_pv = 1'b0;
    endtask

    task automatic step();
        int   cb, ib;
        logic blanked;
        @(posedge clk);
        e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_frame = 1'b0;
        if (bus.en) begin
            cb = ecnt % DIV;
            ib = (ecnt / DIV) % NDIG;
            if (cb == DIV - 1) begin
                e_frame = (ib == NDIG - 1);
            end else begin
                blanked = m_dlz && (ib >= 1) && ((m_disp >> (4 * ib)) == 16'h0);
                e_an    = ~(4'b0001 << ib);
                e_seg   = blanked ? 7'h7F : ref_seg(4'((m_disp >> (4 * ib)) & 16'hF));
                e_dp    = blanked ? 1'b1 : ~m_ddp[ib];
            end
            if (e_frame && m_pv) begin
                m_disp = m_pend; m_ddp = m_pdp; m_dlz = m_plz; m_pv = 1'b0;
            end
            ecnt++;
        end
        if (bus.load) begin
            m_pend = bus.value; m_pdp = bus.dp_in; m_plz = bus.lz_en; m_pv = 1'b1;
        end
        #1;
        chk("out", {19'd0, bus.an, bus.seg, bus.dp, bus.frame},
                   {19'd0, e_an, e_seg, e_dp, e_frame});
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic lz);
        bus.load = 1'b1; bus.value = v; bus.dp_in = d; bus.lz_en = lz;
        step();
        bus.load = 1'b0;
    endtask

    task automatic run_steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Advance until the next enabled edge lands on frame position pos
    task automatic run_until(input int pos);
        int guard = 0;
        while ((ecnt % FRAME) != pos && guard < 2 * FRAME) begin
            step();
            guard++;
        end
        chk("pos_timeout", 32'(guard < 2 * FRAME), 32'd1);
    endtask

    task automatic do_reset();
        bus.load = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_an",    32'(bus.an),    32'hF);
        chk("rst_seg",   32'(bus.seg),   32'h7F);
        chk("rst_dp",    32'(bus.dp),    32'd1);
        chk("rst_frame", 32'(bus.frame), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_hold", {19'd0, bus.an, bus.seg, bus.dp, bus.frame}, {19'd0, 4'hF, 7'h7F, 1'b1, 1'b0});
        rst_n = 1'b1;
    endtask

    initial begin
        bus.en = 1'b1; bus.load = 1'b0; bus.value = '0; bus.dp_in = '0; bus.lz_en = 1'b0;
        model_reset();
        #2;
        do_reset();
        step();
        chk("rel_an",  32'(bus.an),  32'b1110);
        chk("rel_seg", 32'(bus.seg), 32'b0000001);
        run_steps(FRAME);

        // Scan order
        do_load(16'h1258, 4'b0000, 1'b0);
        run_until(FRAME - 1);
        step();
        chk("s2_frame", 32'(bus.frame), 32'd1);
        step();
        chk("s2_seg0", 32'(bus.seg), 32'b0000000);
        chk("s2_an0",  32'(bus.an),  32'b1110);
        run_steps(FRAME + 3);

        // Double buffering
        do_load(16'h1111, 4'b0000, 1'b0);
        run_until(FRAME - 1);
        run_steps(6);
        do_load(16'hFFFF, 4'b0000, 1'b0);
        run_until(FRAME - 1);
        step();
        step();
        chk("s3_segF", 32'(bus.seg), 32'b0111000);
        run_steps(FRAME);

        // Leading-zero suppression
        do_load(16'h0030, 4'b1000, 1'b1);
        run_until(FRAME - 1);
        run_steps(2);
        chk("s4_seg0", 32'(bus.seg), 32'b0000001);
        run_steps(FRAME);
        do_load(16'h0000, 4'b1111, 1'b1);
        run_steps(2 * FRAME);

        // Load coinciding with commit
        do_load(16'h2222, 4'b0101, 1'b0);
        run_until(FRAME - 1);
        do_load(16'h3333, 4'b0000, 1'b0);
        chk("s5_frame", 32'(bus.frame), 32'd1);
        step();
        chk("s5_seg2", 32'(bus.seg), 32'b0010010);
        run_until(FRAME - 1);
        run_steps(2);
        chk("s5_seg3", 32'(bus.seg), 32'b0000110);

        // Enable drop mid-slot, then reset mid-slot
        run_until(2 * DIV + 1);
        bus.en = 1'b0;
        run_steps(10);
        chk("s6_blank", 32'(bus.an), 32'hF);
        bus.en = 1'b1;
        step();
        chk("s6_resume", 32'(bus.an), 32'b1011);
        run_steps(3);
        do_load(16'hABCD, 4'b0011, 1'b0);
        run_steps(2);
        do_reset();
        run_steps(2 * FRAME);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            bus.en    = ($urandom % 10) != 0;
            bus.load  = ($urandom % 8) == 0;
            bus.value = 16'($urandom);
            bus.dp_in = 4'($urandom);
            bus.lz_en = 1'($urandom);
            if (($urandom % 16) < 8) bus.value = bus.value & 16'h00FF;
            step();
            bus.load = 1'b0;
            if (i == 700) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for a bank of common-anode 7-segment digits that share one segment bus. It holds a frame of `NDIG` hex nibbles, steps a one-hot digit select at a divided refresh rate, and drives the shared bus through a single hex-to-segment decoder. Display updates are double-buffered and committed only at frame boundaries, so a visible frame never mixes old and new digits. Optional leading-zero suppression and per-digit decimal points are included.

## Interface
- `NDIG`, 8: number of digits scanned; must be ≥ 2.
- `DIV`, 50000: clock cycles per digit slot; must be ≥ 2.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `en`  in  1  scan enable; 0 blanks all outputs and freezes the divider and index.
- `load`  in  1  single-cycle strobe; captures `value`, `dp_in` and `lz_en` into the pending buffer.
- `value`  in  4*NDIG  nibble k (bits 4k+3:4k) drives digit k; digit 0 is least significant.
- `dp_in`  in  NDIG  decimal-point request per digit, 1 = lit.
- `lz_en`  in  1  leading-zero suppression enable.
- `an`  out  NDIG  digit select, active-low, one-hot-low or all-ones.
- `seg`  out  7  segments, active-low; `seg[6]`=a … `seg[0]`=g.
- `dp`  out  1  decimal point, active-low.
- `frame`  out  1  one-cycle pulse marking the start of each frame.

Clock is `clk`. Reset is `rst_n`, asynchronous and active-low.

## Operation
- **Divider.** `cnt` counts 0..DIV-1 while `en`=1. `tick` is asserted when `cnt`==DIV-1 and `en`=1. `cnt` holds its value while `en`=0.
- **Index.** On `tick`, `idx` advances by one and wraps from NDIG-1 to 0.
- **Pending buffer.** `load` writes `value`, `dp_in` and `lz_en` into the pending buffer and sets `pend_v`.
  - Back-to-back loads overwrite the buffer; the latest load wins.
  - `load` is accepted regardless of `en`.
- **Commit.** On a wrapping `tick` (idx NDIG-1 → 0) with `pend_v`=1:
  - The display register takes the pending contents.
  - The blank mask is computed from the committed value and stored.
  - `pend_v` clears.
  - If `load` arrives in the same cycle as the commit, the committed data is the pre-existing pending contents. The new load becomes pending and `pend_v` stays set.
- **Leading-zero suppression.** With `lz_en`=1, digit k is blanked when all nibbles at positions ≥ k are zero, for k ≥ 1. Digit 0 is never blanked. The decimal point of a blanked digit is also off.
- **Decoder encoding (active-low).**
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111.
  - 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
- **Ghost blanking.** In the cycle immediately after every `tick`, outputs are forced to `an`=all 1, `seg`=7'h7F, `dp`=1.
- **Scan disabled.** `en`=0 forces `an`=all 1, `seg`=7'h7F and `dp`=1 from the next cycle.

## Timing
- All outputs are registered.
- **Reset values:**
  - Outputs: `an`=all 1, `seg`=7'h7F, `dp`=1, `frame`=0.
  - Internal state: `cnt`=0, `idx`=0, display register = 0, mask = 0, `pend_v`=0.
- **After reset release with `en`=1:** the first rising edge drives `an`=~1 (digit 0 low) and `seg`=0000001.
- **Slot timing:** each slot shows one blank cycle followed by DIV-1 lit cycles. A full frame is NDIG·DIV cycles.
- **`frame`** is high during the blank cycle that follows a wrapping tick. This is the first cycle in which committed data can become visible.
- **Load-to-visible latency:** at most (NDIG·DIV)+1 cycles after `load`. It is never earlier than the next wrap.
- **Reset mid-frame** aborts immediately to the reset values and discards any pending data.
- **`en` deassert mid-slot:** `cnt` and `idx` hold. On reassert, the current slot resumes with the same digit and no extra blank cycle.

## Structure
- **Shared package `seg_pkg`:**
  - `seg7_t` (logic [6:0]).
  - Constants `SEG_OFF`=7'h7F and the 16-entry encoding constant array.
- **Combinational sub-module `hex7seg_dec`:** input `hex[3:0]`, output `seg_t`, a pure lookup on the package array. It is instantiated once and fed by the index mux.
- **Remaining logic in `seg_scan_ctrl`:** divider, index, pending/display registers, blank-mask logic and output registers.

## Test plan
All scenarios use NDIG=4 and DIV=4.
1. **Reset:** hold `rst_n`=0 → `an`=4'hF, `seg`=7'h7F, `dp`=1, `frame`=0. Release → next cycle `an`=4'b1110, `seg`=0000001.
2. **Scan order:** load `value`=16'h1258 with `en`=1.
   - After the next `frame` pulse, slots show `an` 1110/1101/1011/0111 with `seg` 0000000 (8), 0100100 (5), 0010010 (2), 1001111 (1).
   - Each slot is 1 blank cycle followed by 3 lit cycles.
3. **Double buffering:** load 16'h1111, then load 16'hFFFF mid-frame → the current frame stays unchanged. The next frame shows all digits `seg`=0111000.
4. **Leading-zero suppression:** `lz_en`=1, `value`=16'h0030, `dp_in`=4'b1000 → digits 3 and 2 have `an` low with `seg`=7'h7F and `dp`=1; digit 1 shows 0000110; digit 0 shows 0000001. With `value`=0, only digit 0 is lit.
5. **Load coinciding with commit:** pending=16'h2222, and a load of 16'h3333 arrives on the wrapping tick → this frame shows 2s, the following frame shows 3s.
6. **Enable and reset mid-frame:** drop `en` for 10 cycles in slot 2 → outputs blank, and digit 2 resumes with its remaining lit cycles. Assert `rst_n` mid-slot → outputs return to reset values within the same cycle.
